// File: rtl/jtdd_obj_buf.sv
// rtl/jtdd_obj_buf.sv - object RAM with CPU port and frame-copied display buffer
// Define JTDD_OBJBUF_EN to build the double buffer; otherwise the engine reads CPU RAM directly.
module jtdd_obj_buf (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] cpu_AB,
  input  logic       cpu_wrn,
  input  logic [7:0] cpu_dout,
  input  logic       oram_cs,
  output logic [7:0] oram_dout,
  input  logic       LVBL,
  input  logic [8:0] oram_addr,
  output logic [7:0] oram_data,
  output logic       busy,
  output logic       copy_done
);

  logic [7:0] cpu_ram [0:511];

  always_ff @(posedge clk) begin
    if (oram_cs && !cpu_wrn) cpu_ram[cpu_AB] <= cpu_dout;
  end

  always_ff @(posedge clk) begin
    if (rst) oram_dout <= 8'h00;
    else     oram_dout <= cpu_ram[cpu_AB];
  end

`ifdef JTDD_OBJBUF_EN
  typedef enum logic [1:0] {IDLE, COPY, DONE} state_t;

  state_t     state;
  logic [8:0] cnt;
  logic [8:0] rd_addr;
  logic [7:0] cp_data;
  logic       lvbl_l;
  logic       trigger;
  logic [7:0] buf_ram [0:511];

  assign trigger = lvbl_l & ~LVBL;
  // The read runs one address ahead of the write; address 0 is fetched on the trigger edge.
  assign rd_addr = (state == COPY) ? cnt + 9'd1 : 9'd0;

  always_ff @(posedge clk) begin
    cp_data <= cpu_ram[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 9'd0;
      lvbl_l    <= 1'b0;
      busy      <= 1'b0;
      copy_done <= 1'b0;
    end else begin
      lvbl_l    <= LVBL;
      copy_done <= 1'b0;
      case (state)
        IDLE: begin
          if (trigger) begin
            state <= COPY;
            cnt   <= 9'd0;
            busy  <= 1'b1;
          end
        end
        COPY: begin
          cnt <= cnt + 9'd1;
          if (cnt == 9'd511) begin
            state     <= DONE;
            busy      <= 1'b0;
            copy_done <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state == COPY) buf_ram[cnt] <= cp_data;
  end

  always_ff @(posedge clk) begin
    if (rst) oram_data <= 8'h00;
    else     oram_data <= buf_ram[oram_addr];
  end
`else
  logic unused_lvbl;

  assign unused_lvbl = LVBL;
  assign busy        = 1'b0;
  assign copy_done   = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) oram_data <= 8'h00;
    else     oram_data <= cpu_ram[oram_addr];
  end
`endif

endmodule
